// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - store-buffered data-memory front end with forwarding and a RAM req/ack port
// Stores queue in a FIFO and drain in the background; loads forward from the youngest match or stall for RAM.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] sb_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, LDONE} state_t;

  state_t             state_q, state_d;
  logic [29:0]        sb_addr_q [DEPTH];
  logic [29:0]        sb_addr_d [DEPTH];
  logic [31:0]        sb_data_q [DEPTH];
  logic [31:0]        sb_data_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;

  logic               hit, ld_req, miss, pop, push, full;
  logic [31:0]        fwd_data;
  logic [PTR_W-1:0]   idx;

  // Oldest-to-youngest scan so the last match wins, covering the entry being drained too.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < count_q && sb_addr_q[idx] == cpu_addr[31:2]) begin
        hit      = 1'b1;
        fwd_data = sb_data_q[idx];
      end
    end
  end

  always_comb begin
    ld_req    = cpu_rd && !cpu_wr;
    miss      = ld_req && !hit && (state_q != LDONE);
    pop       = (state_q == DRAIN) && mem_ack;
    full      = (count_q == CNT_W'(DEPTH));
    push      = cpu_wr && (!full || pop);
    cpu_stall = (cpu_wr && !push) || miss;
    cpu_rdata = (ld_req && hit && state_q != LDONE) ? fwd_data : cpu_rdata_q;

    sb_addr_d = sb_addr_q;
    sb_data_d = sb_data_q;
    if (push) begin
      sb_addr_d[wr_ptr_q] = cpu_addr[31:2];
      sb_data_d[wr_ptr_q] = cpu_wdata;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = LOAD;
               else if (count_q != '0) state_d = DRAIN;
      DRAIN:   if (pop) state_d = miss ? LOAD : IDLE;
      LOAD:    if (mem_ack) state_d = LDONE;
      default: state_d = IDLE;
    endcase

    // Transfer fields are loaded only on entry, so they stay stable until the ack.
    mem_req_d   = (state_d == DRAIN) || (state_d == LOAD);
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == DRAIN && state_q != DRAIN) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = {sb_addr_q[rd_ptr_q], 2'b00};
      mem_wdata_d = sb_data_q[rd_ptr_q];
    end
    if (state_d == LOAD && state_q != LOAD) begin
      mem_we_d   = 1'b0;
      mem_addr_d = cpu_addr & ~32'h3;
    end
    cpu_rdata_d = (state_q == LOAD && mem_ack) ? mem_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      sb_addr_q   <= sb_addr_d;
      sb_data_q   <= sb_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign sb_count  = count_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - directed and randomized bench for dmem_store_buffer
// Reference: program-order memory map for loads, program-order store list for RAM writes.
module tb_dmem_store_buffer;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata;
  logic        cpu_rd, cpu_wr, cpu_stall, mem_req, mem_we;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [2:0]  sb_count;

  int tests = 0;
  int fails = 0;
  int ack_mode = 0;
  int lat = 1;
  int age = 0;
  int st;

  xact_t       log_q[$];
  xact_t       exp_w[$];
  logic [31:0] ram [logic [29:0]];
  logic [31:0] arch [logic [29:0]];

  dmem_store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash(input logic [29:0] w);
    return {w[13:0], 2'b01, ~w[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a[31:2]) ? ram[a[31:2]] : hash(a[31:2]);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a);
    return arch.exists(a[31:2]) ? arch[a[31:2]] : hash(a[31:2]);
  endfunction

  // RAM model: completes transfers at the edge, then sets ack/rdata shortly after it.
  always @(posedge clk) begin
    if (rst && mem_req && mem_ack) begin
      log_q.push_back('{mem_we, mem_addr, mem_wdata});
      if (mem_we) ram[mem_addr[31:2]] = mem_wdata;
      age = 0;
    end
    #2;
    if (!rst) begin
      age = 0;
      mem_ack = 1'b0;
    end else begin
      if (mem_req) age++;
      case (ack_mode)
        0:       mem_ack = 1'b0;
        1:       mem_ack = mem_req && ($urandom_range(0, 1) == 1);
        default: mem_ack = mem_req && (age >= lat);
      endcase
    end
    mem_rdata = ram_rd(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic rd_too,
                          output int stalls);
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1; cpu_rd = rd_too; stalls = 0;
    @(negedge clk);
    while (cpu_stall && stalls < 200) begin stalls++; @(negedge clk); end
    chk("store_timeout", {31'd0, stalls < 200}, 32'd1);
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    arch[a[31:2]] = d;
    exp_w.push_back('{1'b1, a & ~32'h3, d});
  endtask

  task automatic do_load(input logic [31:0] a, output int stalls);
    logic [31:0] e;
    e = exp_load(a);
    cpu_addr = a; cpu_rd = 1'b1; cpu_wr = 1'b0; stalls = 0;
    @(negedge clk);
    while (cpu_stall && stalls < 200) begin stalls++; @(negedge clk); end
    chk("load_timeout", {31'd0, stalls < 200}, 32'd1);
    chk("load_data", cpu_rdata, e);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    ack_mode = 2; lat = 1;
    @(negedge clk);
    while ((sb_count != 3'd0 || mem_req) && n < 300) begin n++; @(negedge clk); end
    chk("drain_timeout", {31'd0, n < 300}, 32'd1);
    @(posedge clk); #1;
    ack_mode = 0;
  endtask

  task automatic check_writes(input string tag);
    xact_t w[$];
    foreach (log_q[i]) if (log_q[i].we) w.push_back(log_q[i]);
    chk({tag, "_count"}, 32'(w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < w.size(); i++) begin
      chk({tag, "_addr"}, w[i].addr, exp_w[i].addr);
      chk({tag, "_data"}, w[i].data, exp_w[i].data);
    end
  endtask

  initial begin
    rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    #3;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_sb_count", {29'd0, sb_count}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Reset in the middle of a drain
    cpu_addr = 32'h10; cpu_wdata = 32'h55; cpu_wr = 1'b1;
    @(posedge clk); #1 cpu_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t1_drain_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_async_req", {31'd0, mem_req}, 32'd0);
    chk("t1_async_count", {29'd0, sb_count}, 32'd0);
    chk("t1_async_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_idle_req", {31'd0, mem_req}, 32'd0);
    chk("t1_idle_count", {29'd0, sb_count}, 32'd0);
    @(posedge clk); #1;

    // Fill the buffer, then a fifth store waits for the first drain ack
    for (int i = 0; i < 4; i++) begin
      do_store(32'h100 + 32'(i) * 4, 32'hD000_0000 + 32'(i), 1'b0, st);
      chk("t2_no_stall", 32'(st), 32'd0);
    end
    chk("t2_count_full", {29'd0, sb_count}, 32'd4);
    cpu_addr = 32'h110; cpu_wdata = 32'hD000_0004; cpu_wr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_full_stall", {31'd0, cpu_stall}, 32'd1);
    end
    @(posedge clk); #1;
    ack_mode = 2; lat = 1;
    do_store(32'h110, 32'hD000_0004, 1'b0, st);
    ack_mode = 0;
    chk("t2_count_after", {29'd0, sb_count}, 32'd4);
    drain_all();
    check_writes("t2_wr");
    log_q.delete(); exp_w.delete();

    // Youngest matching entry forwards with no stall
    do_store(32'h200, 32'h0000_AAAA, 1'b0, st);
    do_store(32'h200, 32'h0000_BBBB, 1'b0, st);
    do_load(32'h202, st);
    chk("t3_no_stall", 32'(st), 32'd0);
    drain_all();
    log_q.delete(); exp_w.delete();

    // Load miss on an empty buffer, RAM ack in the third request cycle
    ram[30'h0C0] = 32'h1234_5678;
    arch[30'h0C0] = 32'h1234_5678;
    ack_mode = 2; lat = 3;
    do_load(32'h300, st);
    ack_mode = 0;
    chk("t4_stall_cycles", 32'(st), 32'd4);
    chk("t4_xacts", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      chk("t4_we", {31'd0, log_q[0].we}, 32'd0);
      chk("t4_addr", log_q[0].addr, 32'h300);
    end
    log_q.delete();

    // A load miss during a drain goes ahead of the remaining store
    do_store(32'h400, 32'h4444_0000, 1'b0, st);
    do_store(32'h404, 32'h4444_0004, 1'b0, st);
    st = 0;
    while (!mem_req && st < 20) begin st++; @(negedge clk); end
    chk("t5_drain_started", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    ack_mode = 2; lat = 2;
    do_load(32'h500, st);
    drain_all();
    chk("t5_xacts", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("t5_0_we", {31'd0, log_q[0].we}, 32'd1);
      chk("t5_0_addr", log_q[0].addr, 32'h400);
      chk("t5_1_we", {31'd0, log_q[1].we}, 32'd0);
      chk("t5_1_addr", log_q[1].addr, 32'h500);
      chk("t5_2_we", {31'd0, log_q[2].we}, 32'd1);
      chk("t5_2_addr", log_q[2].addr, 32'h404);
    end
    log_q.delete(); exp_w.delete();

    // Ten stores with an ack every other cycle, wrapping the pointers
    ack_mode = 2; lat = 2;
    for (int i = 0; i < 10; i++) do_store(32'h600 + 32'(i) * 4, $urandom, 1'b0, st);
    drain_all();
    check_writes("t6_wr");
    chk("t6_final_count", {29'd0, sb_count}, 32'd0);
    log_q.delete(); exp_w.delete();

    // Random mix over a small address window so hits, misses and full stalls all occur
    ack_mode = 1;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0, 1:    do_load(a, st);
        2:       do_store(a, $urandom, 1'b0, st);
        default: do_store(a, $urandom, 1'b1, st);
      endcase
    end
    drain_all();
    check_writes("rand_wr");
    chk("rand_final_count", {29'd0, sb_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
